fifo_flops_cfg: RTL and testbench

Parametrised successor of the flop-based FIFO: same push/pop/full/pndng contract, plus occupancy count, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags and a selectable full-policy (drop new data or overwrite oldest). Storage is a flop array with first-word-fall-through output. It replaces the plain flop FIFO wherever a producer needs back-pressure headroom or a lossy "latest data" buffer, and drops into the existing `fifo_if` environment with the additional signals appended.

---
 rtl/fifo_pkg.sv | 22 ++
 rtl/fifo_ptr_ctr.sv | 31 +++
 rtl/fifo_flops_cfg.sv | 171 +++++++++++++++++
 tb/tb_fifo_flops_cfg.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared types and sizing helpers for the configurable flop FIFO.
// No logic, no latency.
// No flow control; types only.
package fifo_pkg;

    // Behaviour when a push arrives while the FIFO is full and no pop accompanies it.
    typedef enum logic {
        FULL_DROP      = 1'b0,
        FULL_OVERWRITE = 1'b1
    } full_mode_e;

    // Width needed to hold an occupancy in the range 0..d.
    function automatic int fifo_cnt_w(input int d);
        return $clog2(d + 1);
    endfunction

    // Width needed to index d entries; never below one bit.
    function automatic int fifo_ptr_w(input int d);
        return (d > 1) ? $clog2(d) : 1;
    endfunction

endpackage

// File: rtl/fifo_ptr_ctr.sv
// Modulo-depth pointer: advances by one when enabled, wraps from DEPTH-1 to 0.
// Latency: new value visible one cycle after the enabling edge.
// No backpressure; the caller decides when to enable.
module fifo_ptr_ctr
    import fifo_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int PW    = fifo_ptr_w(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_en,
    output logic [PW-1:0] o_ptr
);

    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    logic [PW-1:0] r_ptr;

    // Pointer register: synchronous clear, otherwise step with wrap at the last index.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_ptr <= '0;
        end else if (i_en) begin
            r_ptr <= (r_ptr == LAST) ? '0 : r_ptr + PW'(1);
        end
    end

    assign o_ptr = r_ptr;

endmodule

// File: rtl/fifo_flops_cfg.sv
// Flop-array FIFO with first-word-fall-through output, occupancy, thresholds and sticky errors.
// Latency: a pushed word is visible on Dout the cycle after the push edge when the FIFO was empty.
// Backpressure: full is advisory; a push while full is dropped or overwrites the oldest word per mode.
module fifo_flops_cfg
    import fifo_pkg::*;
#(
    parameter int         depth = 8,
    parameter int         bits  = 16,
    parameter int         af_th = 6,
    parameter int         ae_th = 2,
    parameter full_mode_e mode  = FULL_DROP
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [bits-1:0]              Din,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         clr_err,
    output logic [bits-1:0]              Dout,
    output logic                         full,
    output logic                         pndng,
    output logic                         almost_full,
    output logic                         almost_empty,
    output logic [fifo_cnt_w(depth)-1:0] count,
    output logic                         overflow,
    output logic                         underflow
);

    localparam int CW = fifo_cnt_w(depth);
    localparam int PW = fifo_ptr_w(depth);

    localparam logic [CW-1:0] DEPTH_C = CW'(depth);
    localparam logic [CW-1:0] AF_C    = CW'(af_th);
    localparam logic [CW-1:0] AE_C    = CW'(ae_th);

    // Reject configurations whose thresholds or size make the status flags meaningless.
    if (depth < 2) begin : g_bad_depth
        $error("fifo_flops_cfg: depth must be at least 2");
    end
    if (ae_th < 0 || ae_th >= af_th) begin : g_bad_ae
        $error("fifo_flops_cfg: ae_th must satisfy 0 <= ae_th < af_th");
    end
    if (af_th > depth) begin : g_bad_af
        $error("fifo_flops_cfg: af_th must not exceed depth");
    end

    logic [bits-1:0] r_mem [depth];
    logic [CW-1:0]   r_count;
    logic            r_overflow;
    logic            r_underflow;

    logic [PW-1:0]   w_wr_ptr;
    logic [PW-1:0]   w_rd_ptr;
    logic            w_empty;
    logic            w_full;
    logic            w_do_wr;
    logic            w_do_rd;
    logic            w_ovf_evt;
    logic            w_unf_evt;
    logic [CW-1:0]   w_count_nxt;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == DEPTH_C);

    // Policy decode: which side of the array moves this cycle and which error events fire.
    always_comb begin
        w_do_wr   = 1'b0;
        w_do_rd   = 1'b0;
        w_ovf_evt = 1'b0;
        w_unf_evt = 1'b0;

        // A pop on an empty FIFO is ignored and flagged, even with a push alongside.
        if (pop) begin
            if (w_empty) begin
                w_unf_evt = 1'b1;
            end else begin
                w_do_rd = 1'b1;
            end
        end

        if (push) begin
            if (!w_full || pop) begin
                // A concurrent pop frees the slot the push needs, so full+push+pop is lossless.
                w_do_wr = 1'b1;
            end else begin
                w_ovf_evt = 1'b1;
                if (mode == FULL_OVERWRITE) begin
                    // wr_ptr equals rd_ptr when full: write over the head and advance both.
                    w_do_wr = 1'b1;
                    w_do_rd = 1'b1;
                end
            end
        end
    end

    // Occupancy only changes when exactly one of write/read happens.
    always_comb begin
        w_count_nxt = r_count;
        if (w_do_wr && !w_do_rd) begin
            w_count_nxt = r_count + CW'(1);
        end else if (w_do_rd && !w_do_wr) begin
            w_count_nxt = r_count - CW'(1);
        end
    end

    fifo_ptr_ctr #(
        .DEPTH (depth),
        .PW    (PW)
    ) u_wr_ptr (
        .clk   (clk),
        .rst   (rst),
        .i_en  (w_do_wr),
        .o_ptr (w_wr_ptr)
    );

    fifo_ptr_ctr #(
        .DEPTH (depth),
        .PW    (PW)
    ) u_rd_ptr (
        .clk   (clk),
        .rst   (rst),
        .i_en  (w_do_rd),
        .o_ptr (w_rd_ptr)
    );

    // Storage write; contents are never cleared, but nothing is written while in reset.
    always_ff @(posedge clk) begin
        if (rst && w_do_wr) begin
            r_mem[w_wr_ptr] <= Din;
        end
    end

    // Occupancy register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_count <= '0;
        end else begin
            r_count <= w_count_nxt;
        end
    end

    // Sticky error flags: a new event in the same cycle as clr_err leaves the flag set.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_ovf_evt) begin
                r_overflow <= 1'b1;
            end else if (clr_err) begin
                r_overflow <= 1'b0;
            end
            if (w_unf_evt) begin
                r_underflow <= 1'b1;
            end else if (clr_err) begin
                r_underflow <= 1'b0;
            end
        end
    end

    // All status is decoded from registered state, so there is no input-to-output path.
    assign Dout         = w_empty ? '0 : r_mem[w_rd_ptr];
    assign full         = w_full;
    assign pndng        = !w_empty;
    assign almost_full  = (r_count >= AF_C);
    assign almost_empty = (r_count <= AE_C);
    assign count        = r_count;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule

// File: tb/tb_fifo_flops_cfg.sv
// Self-checking bench: a drop-policy and an overwrite-policy FIFO share one stimulus stream.
// Each has a queue scoreboard that is updated at every clock edge and compared one step later.
// Output is sampled 1 time unit after the rising edge.
module tb_fifo_flops_cfg;
    import fifo_pkg::*;

    localparam int DEPTH = 8;
    localparam int BITS  = 16;
    localparam int AF    = 6;
    localparam int AE    = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [BITS-1:0] din = '0;
    logic            push = 1'b0;
    logic            pop = 1'b0;
    logic            clr_err = 1'b0;

    logic [BITS-1:0] d_dout, o_dout;
    logic            d_full, o_full, d_pndng, o_pndng;
    logic            d_af, o_af, d_ae, o_ae;
    logic [3:0]      d_count, o_count;
    logic            d_ovf, o_ovf, d_unf, o_unf;

    int n_vec = 0;
    int n_err = 0;

    logic [BITS-1:0] q_d [$];
    logic [BITS-1:0] q_o [$];
    logic            m_ovf [2];
    logic            m_unf [2];

    always #5 clk = ~clk;

    fifo_flops_cfg #(
        .depth (DEPTH), .bits (BITS), .af_th (AF), .ae_th (AE), .mode (FULL_DROP)
    ) u_drop (
        .clk (clk), .rst (rst), .Din (din), .push (push), .pop (pop), .clr_err (clr_err),
        .Dout (d_dout), .full (d_full), .pndng (d_pndng), .almost_full (d_af),
        .almost_empty (d_ae), .count (d_count), .overflow (d_ovf), .underflow (d_unf)
    );

    fifo_flops_cfg #(
        .depth (DEPTH), .bits (BITS), .af_th (AF), .ae_th (AE), .mode (FULL_OVERWRITE)
    ) u_ovw (
        .clk (clk), .rst (rst), .Din (din), .push (push), .pop (pop), .clr_err (clr_err),
        .Dout (o_dout), .full (o_full), .pndng (o_pndng), .almost_full (o_af),
        .almost_empty (o_ae), .count (o_count), .overflow (o_ovf), .underflow (o_unf)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h at %0t", tag, act, exp, $time);
        end
    endtask

    // Advance one queue model by one clock edge using the current stimulus.
    task automatic model_step(input int m);
        logic [BITS-1:0] t [$];
        bit was_full, was_empty;
        if (m == 0) t = q_d; else t = q_o;
        if (!rst) begin
            t.delete();
            m_ovf[m] = 1'b0;
            m_unf[m] = 1'b0;
        end else begin
            was_full  = (t.size() == DEPTH);
            was_empty = (t.size() == 0);
            if (pop && !was_empty) void'(t.pop_front());
            if (push) begin
                if (!was_full || pop) begin
                    t.push_back(din);
                end else if (m == 1) begin
                    void'(t.pop_front());
                    t.push_back(din);
                end
            end
            if (push && !pop && was_full) m_ovf[m] = 1'b1;
            else if (clr_err)             m_ovf[m] = 1'b0;
            if (pop && was_empty)         m_unf[m] = 1'b1;
            else if (clr_err)             m_unf[m] = 1'b0;
        end
        if (m == 0) q_d = t; else q_o = t;
    endtask

    task automatic check_dut(input int m);
        logic [BITS-1:0] t [$];
        logic [BITS-1:0] head;
        int sz;
        string p;
        if (m == 0) begin t = q_d; p = "drop"; end else begin t = q_o; p = "ovw"; end
        sz   = t.size();
        head = (sz > 0) ? t[0] : '0;
        if (m == 0) begin
            chk({p, ".count"}, 32'(d_count), 32'(sz));
            chk({p, ".dout"},  32'(d_dout),  32'(head));
            chk({p, ".flags"}, {26'd0, d_full, d_pndng, d_af, d_ae, d_ovf, d_unf},
                {26'd0, sz == DEPTH, sz > 0, sz >= AF, sz <= AE, m_ovf[0], m_unf[0]});
        end else begin
            chk({p, ".count"}, 32'(o_count), 32'(sz));
            chk({p, ".dout"},  32'(o_dout),  32'(head));
            chk({p, ".flags"}, {26'd0, o_full, o_pndng, o_af, o_ae, o_ovf, o_unf},
                {26'd0, sz == DEPTH, sz > 0, sz >= AF, sz <= AE, m_ovf[1], m_unf[1]});
        end
    endtask

    // One clock with the given stimulus; models advance at the edge, DUTs are checked #1 later.
    task automatic cyc(input logic r, input logic p, input logic q,
                       input logic [BITS-1:0] d, input logic c);
        rst = r; push = p; pop = q; din = d; clr_err = c;
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
        check_dut(0);
        check_dut(1);
    endtask

    logic [BITS-1:0] seq;

    initial begin
        m_ovf[0] = 0; m_ovf[1] = 0; m_unf[0] = 0; m_unf[1] = 0;
        #1;
        // Reset state.
        cyc(0, 0, 0, '0, 0);
        cyc(0, 1, 1, 16'hFFFF, 1);
        chk("rst.ae", 32'(d_ae), 32'd1);
        chk("rst.dout", 32'(o_dout), 32'd0);

        // Fill 1..8: thresholds cross at counts 3, 6 and 8; head stays the first word.
        for (int i = 1; i <= DEPTH; i++) cyc(1, 1, 0, 16'(i), 0);
        chk("fill.head", 32'(d_dout), 32'h0001);

        // Push while full: drop keeps 1..8, overwrite loses 1 and appends 0xAAAA.
        cyc(1, 1, 0, 16'hAAAA, 0);
        chk("full.ovf_drop", 32'(d_ovf), 32'd1);
        chk("full.ovf_ovw",  32'(o_ovf), 32'd1);
        for (int i = 0; i < DEPTH; i++) begin
            chk("drain.drop", 32'(d_dout), 32'(i + 1));
            seq = (i == DEPTH - 1) ? 16'hAAAA : 16'(i + 2);
            chk("drain.ovw", 32'(o_dout), 32'(seq));
            cyc(1, 0, 1, '0, 0);
        end
        chk("empty.pndng", 32'(d_pndng), 32'd0);

        // Pop while empty with a simultaneous push, then clear the sticky flags.
        cyc(1, 1, 1, 16'h1234, 0);
        chk("unf.dout", 32'(d_dout), 32'h1234);
        chk("unf.flag", 32'(o_unf), 32'd1);
        cyc(1, 0, 0, '0, 1);
        chk("clr.unf", 32'(d_unf), 32'd0);
        chk("clr.ovf", 32'(o_ovf), 32'd0);

        // Streaming at count 3 and at count 8, wrapping the pointers several times.
        cyc(1, 1, 0, 16'h0100, 0);
        cyc(1, 1, 0, 16'h0101, 0);
        for (int i = 0; i < 20; i++) cyc(1, 1, 1, 16'(16'h0200 + i), 0);
        for (int i = 0; i < 5; i++)  cyc(1, 1, 0, 16'(16'h0300 + i), 0);
        for (int i = 0; i < 20; i++) cyc(1, 1, 1, 16'(16'h0400 + i), 0);
        chk("stream.full", 32'(o_full), 32'd1);
        chk("stream.ovf",  32'(d_ovf),  32'd0);

        // Reset mid-burst at count 5, then recover.
        for (int i = 0; i < 3; i++) cyc(1, 0, 1, '0, 0);
        cyc(0, 1, 0, 16'hDEAD, 0);
        chk("midrst.count", 32'(d_count), 32'd0);
        cyc(1, 1, 0, 16'h5A5A, 0);
        chk("post.dout", 32'(o_dout), 32'h5A5A);

        // Random traffic.
        for (int i = 0; i < 300; i++)
            cyc(($urandom_range(0, 99) != 0), 1'($urandom), 1'($urandom),
                16'($urandom), ($urandom_range(0, 15) == 0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
